// File: rtl/irq_conditioner.sv
// External interrupt front end: per-channel synchroniser, debounce filter,
// rising-edge detect, pending latch with sticky overflow and enable masking.
module irq_conditioner #(
  parameter int unsigned NIRQ      = 3,
  parameter int unsigned DB_CYCLES = 16,
  parameter int unsigned CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [NIRQ-1:0] enable,
  input  logic [NIRQ-1:0] clr,
  output logic [NIRQ-1:0] irq_out,
  output logic [NIRQ-1:0] pending,
  output logic [NIRQ-1:0] ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [NIRQ-1:0]  s1;
  logic [NIRQ-1:0]  s2;
  logic [NIRQ-1:0]  db;
  logic [NIRQ-1:0]  accept;
  logic [NIRQ-1:0]  rise;
  logic [CNT_W-1:0] cnt [NIRQ];

  // Accept fires on the last qualifying clock of a level change; rise is the 0->1 subset.
  always_comb begin
    accept = '0;
    rise   = '0;
    for (int i = 0; i < int'(NIRQ); i++) begin
      accept[i] = (s2[i] != db[i]) && (cnt[i] == CNT_MAX);
      rise[i]   = accept[i] & s2[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < int'(NIRQ); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      for (int i = 0; i < int'(NIRQ); i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A qualified edge beats a same-cycle clear so no request is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      for (int i = 0; i < int'(NIRQ); i++) begin
        if (rise[i] && enable[i]) begin
          if (pending[i]) begin
            ovf[i] <= 1'b1;
          end else begin
            pending[i] <= 1'b1;
          end
        end else if (clr[i]) begin
          pending[i] <= 1'b0;
          ovf[i]     <= 1'b0;
        end
      end
    end
  end

  assign irq_out = pending & enable;

endmodule

// File: tb/tb_irq_conditioner.sv
// Self-checking bench for irq_conditioner: directed scenarios plus a randomized
// run against a sliding-window reference model.
module tb_irq_conditioner;

  localparam int unsigned NIRQ = 3;
  localparam int unsigned DB   = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NIRQ-1:0] irq_in = '0;
  logic [NIRQ-1:0] enable = '0;
  logic [NIRQ-1:0] clr = '0;
  logic [NIRQ-1:0] irq_out;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] ovf;

  int nvec = 0;
  int nerr = 0;

  // Reference model: a level is accepted once the last DB synchronised samples all differ from it.
  logic [NIRQ-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_pend = '0, m_ovf = '0;
  logic [DB-1:0]   m_win [NIRQ];
  int              m_nv  [NIRQ];

  irq_conditioner dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .enable  (enable),
    .clr     (clr),
    .irq_out (irq_out),
    .pending (pending),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    logic acc;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0; m_ovf = '0;
      for (int i = 0; i < int'(NIRQ); i++) begin
        m_win[i] = '0;
        m_nv[i]  = 0;
      end
    end else begin
      for (int i = 0; i < int'(NIRQ); i++) begin
        m_win[i] = {m_win[i][DB-2:0], m_s2[i]};
        if (m_nv[i] < int'(DB)) m_nv[i]++;
        acc = (m_nv[i] == int'(DB)) && (m_win[i] == (m_db[i] ? {DB{1'b0}} : {DB{1'b1}}));
        if (acc) m_db[i] = m_s2[i];
        if (acc && m_s2[i] && enable[i]) begin
          if (m_pend[i]) m_ovf[i] = 1'b1;
          else           m_pend[i] = 1'b1;
        end else if (clr[i]) begin
          m_pend[i] = 1'b0;
          m_ovf[i]  = 1'b0;
        end
      end
      m_s2 = m_s1;
      m_s1 = irq_in;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; irq_in = '0; clr = '0; enable = 3'b111;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    irq_in = 3'b111; enable = 3'b111; clr = '0; reset = 1'b1;
    tick();
    nvec++;
    if ({irq_out, pending, ovf} !== 9'b0) begin
      nerr++;
      $display("FAIL reset outputs=%b expected 000000000", {irq_out, pending, ovf});
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    nvec++;
    if (pending !== 3'b000) begin
      nerr++;
      $display("FAIL reset_early_pending pending=%b expected 000", pending);
    end
  endtask

  task automatic test_clean_pulse();
    do_reset();
    irq_in[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      nvec++;
      if (irq_out[0] !== (k >= 18)) begin
        nerr++;
        $display("FAIL clean_latency edge=%0d irq_out0=%b expected %b", k, irq_out[0], (k >= 18));
      end
    end
    irq_in[0] = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    nvec++;
    if (irq_out[0] !== 1'b1) begin
      nerr++;
      $display("FAIL clean_hold irq_out0=%b expected 1", irq_out[0]);
    end
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    nvec++;
    if ({irq_out[0], pending[0]} !== 2'b00) begin
      nerr++;
      $display("FAIL clean_clear irq_out0/pending0=%b expected 00", {irq_out[0], pending[0]});
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 20; k++) begin
        irq_in[1] = (k < 10);
        tick();
        nvec++;
        if (pending[1] !== 1'b0) begin
          nerr++;
          $display("FAIL glitch rep=%0d k=%0d pending1=%b expected 0", r, k, pending[1]);
        end
      end
    end
    irq_in[1] = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    irq_in[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    nvec++;
    if (pending[1] !== 1'b1) begin
      nerr++;
      $display("FAIL glitch_min_pulse pending1=%b expected 1", pending[1]);
    end
  endtask

  task automatic test_simul_clear();
    do_reset();
    irq_in[2] = 1'b1;
    for (int k = 0; k < 17; k++) tick();
    nvec++;
    if (pending[2] !== 1'b0) begin
      nerr++;
      $display("FAIL simul_pre pending2=%b expected 0", pending[2]);
    end
    clr[2] = 1'b1;
    tick();
    clr[2] = 1'b0;
    nvec++;
    if ({pending[2], ovf[2]} !== 2'b10) begin
      nerr++;
      $display("FAIL simul_set_wins pending2/ovf2=%b expected 10", {pending[2], ovf[2]});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      irq_in[0] = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      irq_in[0] = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      nvec++;
      if ({pending[0], ovf[0]} !== {1'b1, (p == 1)}) begin
        nerr++;
        $display("FAIL overflow pulse=%0d pending0/ovf0=%b expected %b", p, {pending[0], ovf[0]}, {1'b1, (p == 1)});
      end
    end
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    nvec++;
    if ({pending[0], ovf[0]} !== 2'b00) begin
      nerr++;
      $display("FAIL overflow_clear pending0/ovf0=%b expected 00", {pending[0], ovf[0]});
    end
  endtask

  task automatic test_masking();
    do_reset();
    enable = 3'b101;
    irq_in[1] = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    irq_in[1] = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    nvec++;
    if (pending[1] !== 1'b0) begin
      nerr++;
      $display("FAIL mask_discard pending1=%b expected 0", pending[1]);
    end
    enable = 3'b111;
    irq_in[1] = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    irq_in[1] = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    nvec++;
    if ({irq_out[1], pending[1]} !== 2'b11) begin
      nerr++;
      $display("FAIL mask_set irq_out1/pending1=%b expected 11", {irq_out[1], pending[1]});
    end
    enable[1] = 1'b0;
    #1;
    nvec++;
    if ({irq_out[1], pending[1]} !== 2'b01) begin
      nerr++;
      $display("FAIL mask_off irq_out1/pending1=%b expected 01", {irq_out[1], pending[1]});
    end
    enable[1] = 1'b1;
    #1;
    nvec++;
    if (irq_out[1] !== 1'b1) begin
      nerr++;
      $display("FAIL mask_restore irq_out1=%b expected 1", irq_out[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    irq_in[0] = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nvec++;
    if ({irq_out, pending, ovf} !== 9'b0) begin
      nerr++;
      $display("FAIL reset_mid outputs=%b expected 000000000", {irq_out, pending, ovf});
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      nvec++;
      if (pending[0] !== (k >= 18)) begin
        nerr++;
        $display("FAIL reset_requalify edge=%0d pending0=%b expected %b", k, pending[0], (k >= 18));
      end
    end
  endtask

  task automatic test_random();
    int hold [NIRQ];
    do_reset();
    for (int i = 0; i < int'(NIRQ); i++) hold[i] = $urandom_range(1, 40);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < int'(NIRQ); i++) begin
        if (hold[i] == 0) begin
          irq_in[i] = ~irq_in[i];
          hold[i] = $urandom_range(1, 40);
        end else begin
          hold[i]--;
        end
        clr[i] = ($urandom_range(0, 29) == 0);
      end
      if ($urandom_range(0, 99) == 0) enable = 3'($urandom);
      reset = ($urandom_range(0, 699) == 0);
      tick();
      nvec++;
      if ({irq_out, pending, ovf} !== {m_pend & enable, m_pend, m_ovf}) begin
        nerr++;
        $display("FAIL random cycle=%0d irq/pend/ovf=%b expected %b", c,
                 {irq_out, pending, ovf}, {m_pend & enable, m_pend, m_ovf});
      end
    end
    reset = 1'b0;
    clr = '0;
  endtask

  initial begin
    for (int i = 0; i < int'(NIRQ); i++) begin
      m_win[i] = '0;
      m_nv[i]  = 0;
    end
    test_reset();
    test_clean_pulse();
    test_glitch();
    test_simul_clear();
    test_overflow();
    test_masking();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/irq_conditioner.md
# irq_conditioner

External interrupt front end for the vargen picoRV32 SoC, placed directly upstream of the CPU `irq_5`/`irq_6`/`irq_7` inputs. Each asynchronous interrupt pin is synchronised, debounced and rising-edge detected. A per-channel pending latch holds the request until firmware clears it. A sticky overflow flag records a new edge that arrives while the channel is still pending.

## Interface
- `NIRQ`, default 3: number of channels; bit 0 drives `irq_5`, bit 1 `irq_6`, bit 2 `irq_7`.
- `DB_CYCLES`, default 16: consecutive clocks a synchronised level must differ from the stable level before it is accepted; legal range 1..65536.
- `CNT_W`, default `$clog2(DB_CYCLES)` (minimum 1): width of the debounce counter.

Ports:
- `clk` input 1: system clock (25 MHz on ULX3S); the block has one clock.
- `reset` input 1: synchronous, active-high reset.
- `irq_in` input NIRQ: asynchronous external interrupt pins, active high.
- `enable` input NIRQ: per-channel enable, static or from a CPU register.
- `clr` input NIRQ: one-cycle strobes that clear `pending` and `ovf` of the corresponding channel.
- `irq_out` output NIRQ: requests to the CPU; equals `pending & enable`.
- `pending` output NIRQ: latched request status, readable by firmware.
- `ovf` output NIRQ: sticky flag; an edge was detected while the channel was already pending.

## Operation
- Each channel is independent; everything below is stated per channel.
- Synchroniser: two flops, `s1 <= irq_in`, then `s2 <= s1`. Reset value is 0.
- Debounce:
  - State is a stable level `db` and a counter `cnt`, both reset to 0.
  - On a clock where `s2 == db`: `cnt <= 0`.
  - On a clock where `s2 != db` and `cnt == DB_CYCLES-1`: `db <= s2` and `cnt <= 0`. This clock is the *accept*.
  - On a clock where `s2 != db` otherwise: `cnt <= cnt+1`.
  - A glitch lasting fewer than DB_CYCLES clocks at `s2` never changes `db`.
- Edge event: an accept with `s2 == 1` (a 0→1 transition of `db`). Falling accepts only update `db`.
- Pending latch, resolved in this priority order:
  1. Edge event while `enable` is high:
     - If `pending` is already 1, set `ovf`.
     - Otherwise set `pending`.
     - This holds even when `clr` is asserted on the same clock: set wins, so a concurrent clear cannot lose an interrupt.
  2. Otherwise, if `clr` is high: `pending <= 0` and `ovf <= 0`.
  3. An edge event while `enable` is low is discarded; it does not set `pending` or `ovf`.
- `irq_out` is combinational `pending & enable`. Deasserting `enable` masks the output without clearing `pending`.
- `clr` on a channel whose `pending` is 0 has no effect other than clearing `ovf`.

## Timing
- Reset values: all outputs and internal state are 0 on the first clock edge with `reset` high. Reset overrides every other input.
- Reset mid-debounce discards the partial count. A level still present after reset is re-qualified from scratch: an `irq_in` held high through reset produces a fresh edge event after reset.
- Latency: take `irq_in` sampled high at edge E0.
  - `s2` is 1 after edge E1.
  - The accept and `pending` rise happen at edge E(DB_CYCLES+1).
  - `irq_out` is valid immediately after that edge: DB_CYCLES+2 clock edges from the first sampling edge, which is 18 edges at the default.
- Minimum accepted pulse width: DB_CYCLES clocks at `s2`.
- Minimum spacing between two detected edges: 2×DB_CYCLES clocks (high time plus low time).
- `clr` takes effect at the next edge. `pending` and `irq_out` drop in the cycle after the strobe.
- The counter never wraps: it is bounded by DB_CYCLES-1 and returns to 0 on every accept or match.

## Test plan
- Clean pulse: `enable=3'b111`, `irq_in[0]` high for 40 clocks → `irq_out[0]` rises exactly 18 edges after the first sampling edge. `irq_out[0]` stays high after `irq_in` falls. Pulsing `clr[0]` drops it the next cycle.
- Glitch filter: `irq_in[1]` high for 10 clocks, then low, repeated 5 times → `pending[1]` stays 0 throughout. A following 16-clock pulse sets it.
- Simultaneous set/clear: `clr[2]` asserted on exactly the accept clock of a channel-2 edge → after that edge `pending[2]=1` and `ovf[2]=0`.
- Overflow: two qualified pulses on channel 0 without a clear → `ovf[0]=1` and `pending[0]=1`. One `clr[0]` strobe → both are 0.
- Masking: `enable[1]=0` during a qualified pulse → `pending[1]=0`. Separately, with `pending[1]=1`, dropping `enable[1]` gives `irq_out[1]=0` and `pending[1]=1`; restoring `enable[1]` re-asserts `irq_out[1]`.
- Reset mid-operation: assert `reset` for 1 clock while `cnt=10` and `irq_in[0]` is held high → all outputs are 0 after that edge. `pending[0]` rises 18 edges after the first post-reset sampling edge.
